// File: rtl/pc_update_unit_pkg.sv
// Shared selector constants and FSM state encodings for the PC update block.
package pc_defs;

  localparam logic [2:0] PC_SRC_SEQ    = 3'd0;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd1;
  localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
  localparam logic [2:0] PC_SRC_JR     = 3'd3;
  localparam logic [2:0] PC_SRC_EXC    = 3'd4;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

endpackage

// File: rtl/pc_update_unit_pc_src_mux.sv
// Combinational N:1 next-PC source mux; flags selectors beyond NUM_SRC as invalid.
module pc_src_mux #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned SEL_W   = 3
) (
  input  logic [NUM_SRC*WIDTH-1:0] src_flat,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         target,
  output logic                     sel_valid
);

  always_comb begin
    target = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (32'(sel) == k) target = src_flat[k*WIDTH +: WIDTH];
    end
  end

  assign sel_valid = (32'(sel) < NUM_SRC);

endmodule

// File: rtl/pc_update_unit.sv
// PC register with next-PC selection, load qualification and post-redirect flush window.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_update_unit
  import pc_defs::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      NUM_SRC   = 5,
  parameter int unsigned      SEL_W     = 3,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      FLUSH_CYC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_flat,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond_true,
  input  logic                     stall,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         pc_prev,
  output logic                     flush,
  output logic                     sel_err,
  output logic                     align_err
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYC - 1);

  logic [WIDTH-1:0] target;
  logic             sel_valid;
  logic             load_req;
  logic             misaligned;
  logic             accept;
  logic             redirect;
  logic [0:0]       state;
  logic [3:0]       cnt;

  pc_src_mux #(
    .WIDTH  (WIDTH),
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W)
  ) u_src_mux (
    .src_flat (src_flat),
    .sel      (sel),
    .target   (target),
    .sel_valid(sel_valid)
  );

  assign load_req = !stall && (pc_write || (pc_write_cond && cond_true));

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = (target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Out-of-range selects and misaligned targets both veto the load entirely.
  assign accept   = load_req && sel_valid && !misaligned;
  assign redirect = accept && (sel != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      pc_prev <= RESET_PC;
    end else if (accept) begin
      pc      <= target;
      pc_prev <= pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (load_req && !sel_valid) begin
      sel_err <= 1'b1;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      align_err <= 1'b0;
    end else begin
      align_err <= load_req && sel_valid && misaligned;
    end
  end
`else
  assign align_err = 1'b0;
`endif

  // A redirect always (re)opens the window, so FLUSH never needs its own reload path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else if (redirect) begin
      state <= FLUSH;
      cnt   <= CNT_INIT;
    end else if (state == FLUSH) begin
      if (cnt == '0) begin
        state <= RUN;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign flush = (state == FLUSH);

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: directed scenarios plus randomized run vs. a reference model.
module tb_pc_update_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned NS  = 5;
  localparam int unsigned SW  = 3;
  localparam int unsigned FC  = 2;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  src [NS];
  logic [NS*W-1:0] src_flat;
  logic [SW-1:0] sel;
  logic          pc_write, pc_write_cond, cond_true, stall;
  logic [W-1:0]  pc, pc_prev;
  logic          flush, sel_err, align_err;

  int errors = 0;
  int checks = 0;

  // Reference model state: flush is modelled as "cycles of window remaining".
  logic [31:0] m_pc, m_prev;
  int          m_rem;
  logic        m_sel_err, m_align;

  pc_update_unit #(
    .WIDTH    (W),
    .NUM_SRC  (NS),
    .SEL_W    (SW),
    .RESET_PC (RPC),
    .FLUSH_CYC(FC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_flat     (src_flat),
    .sel          (sel),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .cond_true    (cond_true),
    .stall        (stall),
    .pc           (pc),
    .pc_prev      (pc_prev),
    .flush        (flush),
    .sel_err      (sel_err),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_flat = '0;
    for (int k = 0; k < NS; k++) src_flat[k*W +: W] = src[k];
  end

  task automatic idle();
    pc_write = 1'b0; pc_write_cond = 1'b0; cond_true = 1'b0; stall = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = RPC; m_prev = RPC; m_rem = 0; m_sel_err = 1'b0; m_align = 1'b0;
  endtask

  // One clock: evaluate the rules on the current inputs, advance, land 1ns after the edge.
  task automatic tick();
    logic lr, v, mis, acc;
    logic [31:0] tgt;
    lr  = !stall && (pc_write || (pc_write_cond && cond_true));
    v   = (int'(sel) < NS);
    tgt = v ? src[sel] : 32'h0;
`ifdef PC_ALIGN_CHECK_EN
    mis = v && (tgt[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    acc = lr && v && !mis;
    @(posedge clk);
    if (acc) begin m_prev = m_pc; m_pc = tgt; end
    if (lr && !v) m_sel_err = 1'b1;
    m_align = lr && v && mis;
    if (acc && sel != 0) m_rem = FC;
    else if (m_rem > 0) m_rem--;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle();
    sel = '0;
    for (int k = 0; k < NS; k++) src[k] = 32'h0;
    reset = 1'b1;
    #12;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (pc !== RPC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RPC); end
    checks++; if (pc_prev !== RPC) begin errors++; $display("FAIL reset_pc_prev: got %h expected %h", pc_prev, RPC); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b expected 0", sel_err); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err: got %b expected 0", align_err); end
    // Redirect to 0x40 so the window is open, then reset asynchronously mid-cycle.
    sel = 3'd1; src[1] = 32'h40; pc_write = 1'b1;
    tick();
    idle();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL midrun_pc: got %h expected 40", pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL midrun_flush: got %b expected 1", flush); end
    reset = 1'b1;
    #2;
    checks++; if (pc !== RPC) begin errors++; $display("FAIL async_reset_pc: got %h expected %h", pc, RPC); end
    checks++; if (pc_prev !== RPC) begin errors++; $display("FAIL async_reset_pc_prev: got %h expected %h", pc_prev, RPC); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL async_reset_flush: got %b expected 0", flush); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL async_reset_sel_err: got %b expected 0", sel_err); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_seq_load();
    sel = 3'd0; src[0] = 32'h4; pc_write = 1'b1;
    tick();
    idle();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc: got %h expected 4", pc); end
    checks++; if (pc_prev !== 32'h0) begin errors++; $display("FAIL seq_pc_prev: got %h expected 0", pc_prev); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq_flush: got %b expected 0", flush); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq_flush_later: got %b expected 0", flush); end
  endtask

  task automatic test_cond_branch();
    sel = 3'd1; src[1] = 32'h100; pc_write_cond = 1'b1; cond_true = 1'b0;
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL cond_false_pc: got %h expected 4", pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL cond_false_flush: got %b expected 0", flush); end
    cond_true = 1'b1;
    tick();
    idle();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL cond_true_pc: got %h expected 100", pc); end
    checks++; if (pc_prev !== 32'h4) begin errors++; $display("FAIL cond_true_pc_prev: got %h expected 4", pc_prev); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL cond_flush_c1: got %b expected 1", flush); end
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL cond_flush_c2: got %b expected 1", flush); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL cond_flush_end: got %b expected 0", flush); end
  endtask

  task automatic test_back_to_back();
    sel = 3'd1; src[1] = 32'h180; pc_write = 1'b1;
    tick();
    idle();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush_c1: got %b expected 1", flush); end
    sel = 3'd2; src[2] = 32'h200; pc_write = 1'b1;
    tick();
    idle();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL b2b_pc: got %h expected 200", pc); end
    checks++; if (pc_prev !== 32'h180) begin errors++; $display("FAIL b2b_pc_prev: got %h expected 180", pc_prev); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush_c2: got %b expected 1", flush); end
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush_c3: got %b expected 1", flush); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_flush_end: got %b expected 0", flush); end
  endtask

  task automatic test_stall_and_sel_err();
    stall = 1'b1; pc_write = 1'b1; sel = 3'd3; src[3] = 32'h300;
    tick();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL stall_pc: got %h expected 200", pc); end
    checks++; if (pc_prev !== 32'h180) begin errors++; $display("FAIL stall_pc_prev: got %h expected 180", pc_prev); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL stall_flush: got %b expected 0", flush); end
    stall = 1'b0; sel = 3'd5;
    tick();
    idle();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL bad_sel_pc: got %h expected 200", pc); end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL bad_sel_err: got %b expected 1", sel_err); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL bad_sel_flush: got %b expected 0", flush); end
    sel = 3'd7;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_sticky: got %b expected 1", sel_err); end
    do_reset();
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL sel_err_cleared: got %b expected 0", sel_err); end
  endtask

  task automatic test_align();
    sel = 3'd3; src[3] = 32'h102; pc_write = 1'b1;
    tick();
    idle();
`ifdef PC_ALIGN_CHECK_EN
    checks++; if (pc !== RPC) begin errors++; $display("FAIL align_pc: got %h expected %h", pc, RPC); end
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_err_pulse: got %b expected 1", align_err); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL align_flush: got %b expected 0", flush); end
`else
    checks++; if (pc !== 32'h102) begin errors++; $display("FAIL align_pc: got %h expected 102", pc); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_err_tied: got %b expected 0", align_err); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL align_flush: got %b expected 1", flush); end
`endif
    tick();
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_err_end: got %b expected 0", align_err); end
    // Out-of-range sel wins over a misaligned-looking request: sel_err only.
    sel = 3'd6; pc_write = 1'b1;
    tick();
    idle();
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_vs_sel: got %b expected 0", align_err); end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_over_align: got %b expected 1", sel_err); end
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      for (int k = 0; k < NS; k++) begin
        src[k] = $urandom;
        if ($urandom_range(0, 7) != 0) src[k][1:0] = 2'b00;
      end
      if ($urandom_range(0, 19) == 0) sel = SW'($urandom_range(NS, 7));
      else sel = SW'($urandom_range(0, NS - 1));
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = ($urandom_range(0, 2) == 0);
      cond_true     = $urandom_range(0, 1) == 1;
      stall         = ($urandom_range(0, 3) == 0);
      tick();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, pc, m_pc); end
      checks++; if (pc_prev !== m_prev) begin errors++; $display("FAIL rnd_pc_prev[%0d]: got %h expected %h", i, pc_prev, m_prev); end
      checks++; if (flush !== (m_rem > 0)) begin errors++; $display("FAIL rnd_flush[%0d]: got %b expected %b", i, flush, m_rem > 0); end
      checks++; if (sel_err !== m_sel_err) begin errors++; $display("FAIL rnd_sel_err[%0d]: got %b expected %b", i, sel_err, m_sel_err); end
      checks++; if (align_err !== m_align) begin errors++; $display("FAIL rnd_align_err[%0d]: got %b expected %b", i, align_err, m_align); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_seq_load();
    test_cond_branch();
    test_back_to_back();
    test_stall_and_sel_err();
    test_align();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
